// File: rtl/bus_initiator_6809.sv
// 6809-style bus master: request/response handshake in, E/Q quadrature bus cycles out.
// Optional MRDY stretch timeout is enabled with `define MRDY_TIMEOUT_EN.
module bus_initiator_6809 #(
    parameter logic [15:0] IDLE_ADDR = 16'hFFFF
`ifdef MRDY_TIMEOUT_EN
    , parameter int STRETCH_MAX = 16
`endif
) (
    input  logic        CLKX4,
    input  logic        nRESET,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [15:0] REQ_ADDR,
    input  logic        REQ_RnW,
    input  logic [7:0]  REQ_WDATA,
    output logic        RSP_VALID,
    output logic [7:0]  RSP_RDATA,
    output logic        RSP_ERR,
    output logic        Q,
    output logic        E,
    output logic [15:0] ADDR,
    output logic        RnW,
    output logic        BA,
    output logic        BS,
    inout  wire  [7:0]  DATA,
    input  logic        MRDY
);

    localparam logic [1:0] P0 = 2'd0;
    localparam logic [1:0] P1 = 2'd1;
    localparam logic [1:0] P2 = 2'd2;
    localparam logic [1:0] P3 = 2'd3;

    logic [1:0]  phase_q, phase_d;
    logic        q_q, q_d, e_q, e_d;
    logic        active_q, active_d;
    logic [15:0] addr_q, addr_d;
    logic        rnw_q, rnw_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        timeout;
    logic        stall;
    logic        data_oe;

`ifdef MRDY_TIMEOUT_EN
    localparam logic [4:0] STRETCH_LIM = 5'(STRETCH_MAX);
    logic [4:0] stretch_cnt_q, stretch_cnt_d;

    // A real MRDY completion wins over a timeout landing on the same clock.
    assign timeout = (phase_q == P3) && active_q && !MRDY && (stretch_cnt_q == STRETCH_LIM);

    always_comb begin
        stretch_cnt_d = stretch_cnt_q;
        if (phase_q == P2) begin
            stretch_cnt_d = 5'd0;
        end else if (stall) begin
            stretch_cnt_d = stretch_cnt_q + 5'd1;
        end
    end

    always_ff @(posedge CLKX4 or negedge nRESET) begin
        if (!nRESET) begin
            stretch_cnt_q <= 5'd0;
        end else begin
            stretch_cnt_q <= stretch_cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign stall = (phase_q == P3) && active_q && !MRDY && !timeout;

    always_ff @(posedge CLKX4 or negedge nRESET) begin
        if (!nRESET) begin
            phase_q <= P0;
            q_q     <= 1'b0;
            e_q     <= 1'b0;
        end else begin
            phase_q <= phase_d;
            q_q     <= q_d;
            e_q     <= e_d;
        end
    end

    // Q and E are decoded from the next phase so both come straight off flops.
    always_comb begin
        phase_d = stall ? P3 : phase_q + 2'd1;
        q_d     = (phase_d == P1) || (phase_d == P2);
        e_d     = (phase_d == P2) || (phase_d == P3);
    end

    always_comb begin
        REQ_READY = 1'b0;
        data_oe   = 1'b0;
        if (phase_q == P3) begin
            REQ_READY = !active_q || MRDY || timeout;
        end
        if (active_q && !rnw_q && (phase_q != P0)) begin
            data_oe = 1'b1;
        end
    end

    // REQ_READY doubles as the end-of-cycle strobe: it is high exactly on P3 clocks that exit to P0.
    always_comb begin
        active_d    = active_q;
        addr_d      = addr_q;
        rnw_d       = rnw_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (REQ_READY) begin
            if (active_q) begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = timeout;
                rsp_rdata_d = timeout ? 8'hFF : (rnw_q ? DATA : 8'h00);
            end
            if (REQ_VALID) begin
                active_d = 1'b1;
                addr_d   = REQ_ADDR;
                rnw_d    = REQ_RnW;
                wdata_d  = REQ_WDATA;
            end else begin
                active_d = 1'b0;
                addr_d   = IDLE_ADDR;
                rnw_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge CLKX4 or negedge nRESET) begin
        if (!nRESET) begin
            active_q    <= 1'b0;
            addr_q      <= IDLE_ADDR;
            rnw_q       <= 1'b1;
            wdata_q     <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            rsp_err_q   <= 1'b0;
        end else begin
            active_q    <= active_d;
            addr_q      <= addr_d;
            rnw_q       <= rnw_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign Q         = q_q;
    assign E         = e_q;
    assign ADDR      = addr_q;
    assign RnW       = rnw_q;
    assign BA        = 1'b0;
    assign BS        = 1'b0;
    assign DATA      = data_oe ? wdata_q : 8'hzz;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_RDATA = rsp_rdata_q;
    assign RSP_ERR   = rsp_err_q;

endmodule

// File: tb/tb_bus_initiator_6809.sv
// Bench for bus_initiator_6809: directed + random requests, a bus slave that answers reads,
// an MRDY stretch driver, and a scoreboard fed at acceptance and drained by a bus/response monitor.
module tb_bus_initiator_6809;

`ifdef MRDY_TIMEOUT_EN
    localparam int STALL_LIM = 16;
`else
    localparam int STALL_LIM = 1 << 30;
`endif

    logic        CLKX4 = 1'b0;
    logic        nRESET = 1'b1;
    logic        REQ_VALID = 1'b0;
    logic [15:0] REQ_ADDR = 16'h0000;
    logic        REQ_RnW = 1'b1;
    logic [7:0]  REQ_WDATA = 8'h00;
    logic        MRDY = 1'b1;
    logic        REQ_READY, RSP_VALID, RSP_ERR, Q, E, RnW, BA, BS;
    logic [7:0]  RSP_RDATA;
    logic [15:0] ADDR;
    wire  [7:0]  DATA;

    bus_initiator_6809 dut (
        .CLKX4(CLKX4), .nRESET(nRESET),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ADDR(REQ_ADDR),
        .REQ_RnW(REQ_RnW), .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .Q(Q), .E(E), .ADDR(ADDR), .RnW(RnW), .BA(BA), .BS(BS),
        .DATA(DATA), .MRDY(MRDY)
    );

    // Clock and cycle count
    always #5 CLKX4 = ~CLKX4;
    int cyc = 0;
    always @(posedge CLKX4) cyc <= cyc + 1;

    // Bus slave: answers reads while E is high
    function automatic logic [7:0] slave_val(input logic [15:0] a);
        return (a == 16'hFE10) ? 8'h07 : (a[7:0] ^ a[15:8] ^ 8'h3C);
    endfunction
    assign DATA = (E && RnW) ? slave_val(ADDR) : 8'hzz;

    int n_vec = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Scoreboard
    logic [7:0] exp_q[$];
    logic       exp_err_q[$];
    int         exp_cyc_q[$];

    // Acceptance notices from the driver to the monitor and the MRDY driver
    int          acc_gen = 0;
    logic [15:0] acc_addr;
    logic        acc_rnw;
    logic [7:0]  acc_wdata;
    int          stall_gen = 0;
    int          stall_set = 0;

    // MRDY driver: holds MRDY low for the requested number of P3 clocks
    int stall_left = 0;
    int last_stall_gen = 0;
    always @(negedge CLKX4) begin
        if (!nRESET) begin
            stall_left = 0;
            last_stall_gen = stall_gen;
            MRDY = 1'b1;
        end else begin
            if (stall_gen != last_stall_gen) begin
                last_stall_gen = stall_gen;
                stall_left = stall_set;
            end
            if (!Q && E && stall_left > 0) begin
                MRDY = 1'b0;
                stall_left = stall_left - 1;
            end else begin
                MRDY = 1'b1;
            end
        end
    end

    task automatic issue(input logic [15:0] a, input logic rnw, input logic [7:0] wd,
                         input int stalls, output int acc);
        int   waited;
        bit   ok;
        int   eff;
        bit   hit;
        waited = 0;
        ok = 0;
        acc = -1;
        @(negedge CLKX4);
        REQ_VALID = 1'b1;
        REQ_ADDR  = a;
        REQ_RnW   = rnw;
        REQ_WDATA = wd;
        while (!ok && waited < 200) begin
            #1;
            if (REQ_READY) begin
                @(posedge CLKX4);
                #1;
                acc = cyc;
                ok = 1;
                hit = (stalls > STALL_LIM);
                eff = hit ? STALL_LIM : stalls;
                exp_q.push_back(hit ? 8'hFF : (rnw ? slave_val(a) : 8'h00));
                exp_err_q.push_back(hit);
                exp_cyc_q.push_back(acc + 4 + eff);
                acc_addr  = a;
                acc_rnw   = rnw;
                acc_wdata = wd;
                acc_gen++;
                stall_set = stalls;
                stall_gen++;
                REQ_VALID = 1'b0;
                REQ_ADDR  = 16'($urandom);
                REQ_RnW   = 1'($urandom);
                REQ_WDATA = 8'($urandom);
            end else begin
                @(negedge CLKX4);
                waited++;
            end
        end
        if (!ok) begin
            check("req_accept_timeout", 32'd0, 32'd1);
            REQ_VALID = 1'b0;
        end
    endtask

    // Monitor: tracks the expected bus cycle and checks phases, bus and responses
    logic [1:0]  qe, exp_qe, prev_qe = 2'b00;
    logic        prev_mrdy = 1'b1, prev_active = 1'b0;
    int          stall_run = 0;
    int          seen_gen = 0;
    logic        cur_active = 1'b0, cur_rnw = 1'b1;
    logic [15:0] cur_addr = 16'hFFFF;
    logic [7:0]  cur_wdata = 8'h00;
    always @(negedge CLKX4) begin
        #2;
        if (!nRESET) begin
            exp_q.delete();
            exp_err_q.delete();
            exp_cyc_q.delete();
            prev_qe = 2'b00;
            prev_active = 1'b0;
            stall_run = 0;
            seen_gen = acc_gen;
            cur_active = 1'b0;
            cur_addr = 16'hFFFF;
            cur_rnw = 1'b1;
        end else begin
            qe = {Q, E};
            if (acc_gen != seen_gen) begin
                seen_gen = acc_gen;
                cur_active = 1'b1;
                cur_addr = acc_addr;
                cur_rnw = acc_rnw;
                cur_wdata = acc_wdata;
            end else if (RSP_VALID) begin
                cur_active = 1'b0;
                cur_addr = 16'hFFFF;
                cur_rnw = 1'b1;
            end
            case (prev_qe)
                2'b00:   exp_qe = 2'b10;
                2'b10:   exp_qe = 2'b11;
                2'b11:   exp_qe = 2'b01;
                default: exp_qe = (prev_active && !prev_mrdy && stall_run < STALL_LIM) ? 2'b01 : 2'b00;
            endcase
            check("qe_phase", 32'(qe), 32'(exp_qe));
            stall_run = (prev_qe == 2'b01 && qe == 2'b01) ? stall_run + 1 : 0;
            check("bus_addr", 32'(ADDR), 32'(cur_addr));
            check("bus_rnw", 32'(RnW), 32'(cur_rnw));
            if (cur_active && !cur_rnw && qe != 2'b00) check("bus_wdata", 32'(DATA), 32'(cur_wdata));
            if (RSP_VALID) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    check("rsp_rdata", 32'(RSP_RDATA), 32'(exp_q.pop_front()));
                    check("rsp_err", 32'(RSP_ERR), 32'(exp_err_q.pop_front()));
                    check("rsp_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
                end
            end
            prev_qe = qe;
            prev_mrdy = MRDY;
            prev_active = cur_active;
        end
    end

    initial begin
        int a0, a1, a2, a3, a4, a5, a6, a7, waited, gap, stalls;
        logic rnw;
        #1 nRESET = 1'b0;
        repeat (3) @(negedge CLKX4);
        #3;
        check("rst_q", 32'(Q), 32'd0);
        check("rst_e", 32'(E), 32'd0);
        check("rst_addr", 32'(ADDR), 32'hFFFF);
        check("rst_rnw", 32'(RnW), 32'd1);
        check("rst_req_ready", 32'(REQ_READY), 32'd0);
        check("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
        check("rst_rsp_rdata", 32'(RSP_RDATA), 32'd0);
        check("rst_rsp_err", 32'(RSP_ERR), 32'd0);
        check("ba_bs", 32'({BA, BS}), 32'd0);
        nRESET = 1'b1;
        repeat (12) @(negedge CLKX4);

        issue(16'hFE11, 1'b0, 8'h15, 0, a0);
        issue(16'hFE10, 1'b1, 8'h00, 0, a1);
        repeat (8) @(negedge CLKX4);

        issue(16'h1234, 1'b1, 8'h00, 3, a2);
        issue(16'h4321, 1'b0, 8'h5A, 0, a3);
        check("held_req_accept_gap", 32'(a3 - a2), 32'd7);
        repeat (8) @(negedge CLKX4);

        issue(16'h0000, 1'b0, 8'hAA, 0, a4);
        issue(16'h8000, 1'b1, 8'h00, 0, a5);
        check("b2b_accept_gap", 32'(a5 - a4), 32'd4);
        repeat (8) @(negedge CLKX4);

`ifdef MRDY_TIMEOUT_EN
        issue(16'hFE10, 1'b1, 8'h00, 20, a6);
        repeat (30) @(negedge CLKX4);
`else
        a6 = 0;
`endif

        issue(16'h2000, 1'b1, 8'h00, 30, a7);
        repeat (6) @(negedge CLKX4);
        #3 nRESET = 1'b0;
        #1;
        check("midrst_e", 32'(E), 32'd0);
        check("midrst_q", 32'(Q), 32'd0);
        check("midrst_addr", 32'(ADDR), 32'hFFFF);
        check("midrst_rsp_valid", 32'(RSP_VALID), 32'd0);
        repeat (3) @(negedge CLKX4);
        #3 nRESET = 1'b1;
        repeat (8) @(negedge CLKX4);

        for (int i = 0; i < 40; i++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge CLKX4);
            rnw = 1'($urandom);
            stalls = ($urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, 5);
`ifdef MRDY_TIMEOUT_EN
            if ($urandom_range(0, 9) == 0) stalls = $urandom_range(17, 24);
`endif
            issue(16'($urandom), rnw, 8'($urandom), stalls, a0);
        end

        waited = 0;
        while (exp_q.size() != 0 && waited < 300) begin
            @(negedge CLKX4);
            waited++;
        end
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge CLKX4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
